// File: rtl/softmax_sched_pkg.sv
// Shared types and sizing helpers for the row-serial softmax scheduler.
// Widths are derived here so the scheduler and its wrappers agree on packing.
package softmax_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } sched_state_e;

    // Bits occupied by one matrix row (one engine transaction).
    function automatic int unsigned row_width(input int unsigned data_width,
                                              input int unsigned elems);
        return data_width * elems;
    endfunction

    function automatic int unsigned idx_width(input int unsigned rows);
        return (rows <= 32'd1) ? 32'd1 : $clog2(rows);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout == 32'd0) ? 32'd1 : $clog2(timeout + 32'd1);
    endfunction

endpackage

// File: rtl/softmax_row_scheduler.sv
// Latches a matrix, feeds its rows one at a time to a shared softmax engine
// and reassembles the result rows into the output matrix.
module softmax_row_scheduler
    import softmax_sched_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int INPUT_SHAPE_1  = 128,
    parameter int INPUT_SHAPE_2  = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                              clk_p,
    input  logic                                              rst_n,
    input  logic [DATA_WIDTH*INPUT_SHAPE_1*INPUT_SHAPE_2-1:0] matrix,
    input  logic                                              input_valid_n,
    output logic                                              input_ready_n,
    output logic [DATA_WIDTH*INPUT_SHAPE_1*INPUT_SHAPE_2-1:0] softmax_matrix,
    output logic                                              output_valid_n,
    output logic                                              busy,
    output logic                                              timeout_err,
    output logic [DATA_WIDTH*INPUT_SHAPE_2-1:0]               eng_inputs,
    output logic                                              eng_valid_n,
    input  logic [DATA_WIDTH*INPUT_SHAPE_2-1:0]               eng_outputs,
    input  logic                                              eng_valid_out_n
);

    localparam int R     = INPUT_SHAPE_1;
    localparam int RW    = int'(row_width(DATA_WIDTH, INPUT_SHAPE_2));
    localparam int MW    = RW * R;
    localparam int IDX_W = int'(idx_width(R));
    localparam int CNT_W = int'(cnt_width(TIMEOUT_CYCLES));

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(R - 1);
    localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    sched_state_e     r_state;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_tmo_cnt;
    logic [MW-1:0]    r_in_buf;
    logic [MW-1:0]    r_out;
    logic [RW-1:0]    r_eng_in;
    logic             r_eng_valid_n;
    logic             r_out_valid_n;
    logic             r_ready_n;
    logic             r_busy;
    logic             r_tmo_err;

    logic [RW-1:0]    w_in_rows [R];
    logic [MW-1:0]    w_out_next;
    logic [IDX_W-1:0] w_next_idx;
    logic [RW-1:0]    w_next_row;

    // Row mux source and the row-write merge of the engine result into the output image.
    for (genvar g = 0; g < R; g++) begin : g_rows
        assign w_in_rows[g] = r_in_buf[g*RW +: RW];
        assign w_out_next[g*RW +: RW] = (r_idx == IDX_W'(g)) ? eng_outputs
                                                              : r_out[g*RW +: RW];
    end

    assign w_next_idx = r_idx + IDX_W'(1);
    assign w_next_row = w_in_rows[w_next_idx];

    // Scheduler FSM; every output is a register loaded on the transition into its state.
    always_ff @(posedge clk_p) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_tmo_cnt     <= '0;
            r_in_buf      <= '0;
            r_out         <= '0;
            r_eng_in      <= '0;
            r_eng_valid_n <= 1'b1;
            r_out_valid_n <= 1'b1;
            r_ready_n     <= 1'b0;
            r_busy        <= 1'b0;
            r_tmo_err     <= 1'b0;
        end else begin
            r_eng_valid_n <= 1'b1;
            r_out_valid_n <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (!input_valid_n) begin
                        r_in_buf      <= matrix;
                        r_idx         <= '0;
                        r_tmo_err     <= 1'b0;
                        r_eng_in      <= matrix[RW-1:0];
                        r_eng_valid_n <= 1'b0;
                        r_ready_n     <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= S_ISSUE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    r_tmo_cnt <= '0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (!eng_valid_out_n) begin
                        r_out <= w_out_next;
                        if (r_idx == LAST_IDX) begin
                            r_out_valid_n <= 1'b0;
                            r_state       <= S_DONE;
                        end else begin
                            r_idx         <= w_next_idx;
                            r_eng_in      <= w_next_row;
                            r_eng_valid_n <= 1'b0;
                            r_state       <= S_ISSUE;
                        end
                    end else if (TMO_EN && (r_tmo_cnt == TMO_LAST)) begin
                        // Abandon the matrix: no output pulse, error stays until next accept.
                        r_tmo_err <= 1'b1;
                        r_ready_n <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_ready_n <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_ready_n <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign input_ready_n  = r_ready_n;
    assign softmax_matrix = r_out;
    assign output_valid_n = r_out_valid_n;
    assign busy           = r_busy;
    assign timeout_err    = r_tmo_err;
    assign eng_inputs     = r_eng_in;
    assign eng_valid_n    = r_eng_valid_n;

endmodule

// File: tb/tb_softmax_row_scheduler.sv
// Directed/random bench for softmax_row_scheduler with a latency-configurable
// engine model that returns each element of the issued row plus one.
module tb_softmax_row_scheduler;

    localparam int DW  = 8;
    localparam int R   = 4;
    localparam int N   = 4;
    localparam int TMO = 8;
    localparam int RW  = DW * N;
    localparam int MW  = RW * R;

    logic          clk_p = 1'b0;
    logic          rst_n;
    logic [MW-1:0] matrix;
    logic          input_valid_n;
    logic          input_ready_n;
    logic [MW-1:0] softmax_matrix;
    logic          output_valid_n;
    logic          busy;
    logic          timeout_err;
    logic [RW-1:0] eng_inputs;
    logic          eng_valid_n;
    logic [RW-1:0] eng_outputs;
    logic          eng_valid_out_n;

    int errors = 0;
    int checks = 0;
    int eng_mode = 0;   // 0: fixed latency, 1: always valid, 2: never responds
    int eng_lat = 3;
    int eng_pend = 0;
    int eng_cnt = 0;

    softmax_row_scheduler #(
        .DATA_WIDTH    (DW),
        .INPUT_SHAPE_1 (R),
        .INPUT_SHAPE_2 (N),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_p          (clk_p),
        .rst_n          (rst_n),
        .matrix         (matrix),
        .input_valid_n  (input_valid_n),
        .input_ready_n  (input_ready_n),
        .softmax_matrix (softmax_matrix),
        .output_valid_n (output_valid_n),
        .busy           (busy),
        .timeout_err    (timeout_err),
        .eng_inputs     (eng_inputs),
        .eng_valid_n    (eng_valid_n),
        .eng_outputs    (eng_outputs),
        .eng_valid_out_n(eng_valid_out_n)
    );

    always #5 clk_p = ~clk_p;

    // Engine data path: every element of the presented row incremented.
    always_comb begin
        eng_outputs = '0;
        for (int e = 0; e < N; e++) eng_outputs[e*DW +: DW] = eng_inputs[e*DW +: DW] + 8'd1;
    end

    // Engine handshake: first valid cycle comes eng_lat cycles after the start pulse.
    always @(posedge clk_p) begin
        if (eng_mode == 0) begin
            eng_valid_out_n <= 1'b1;
            if (!eng_valid_n) begin
                eng_pend = 1;
                eng_cnt  = eng_lat - 1;
            end
            if (eng_pend != 0) begin
                if (eng_cnt == 0) begin
                    eng_valid_out_n <= 1'b0;
                    eng_pend = 0;
                end else begin
                    eng_cnt = eng_cnt - 1;
                end
            end
        end else if (eng_mode == 1) begin
            eng_valid_out_n <= 1'b0;
            eng_pend = 0;
        end else begin
            eng_valid_out_n <= 1'b1;
            eng_pend = 0;
        end
    end

    task automatic tick();
        @(posedge clk_p);
        #1;
    endtask

    task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] m;
        for (int i = 0; i < MW / 32; i++) m[i*32 +: 32] = $urandom;
        return m;
    endfunction

    function automatic logic [RW-1:0] row_of(input logic [MW-1:0] m, input int k);
        return m[k*RW +: RW];
    endfunction

    // Reference softmax stand-in: each element of the whole matrix plus one, modulo 2^DW.
    function automatic logic [MW-1:0] expect_mat(input logic [MW-1:0] m);
        logic [MW-1:0] r;
        for (int i = 0; i < R * N; i++) r[i*DW +: DW] = m[i*DW +: DW] + 8'd1;
        return r;
    endfunction

    // Runs one or two matrices, checking every cycle against the closed-form schedule.
    task automatic run_seq(input int lat, input int mode, input logic [MW-1:0] m0,
                           input logic [MW-1:0] m1, input int nmat, input bit pulses);
        int per, span, last, t, rel, j, row;
        bit busy_e, eng_e, ov_e;
        per  = R * (lat + 1) + 2;
        span = R * (lat + 1) + 1;
        last = (nmat - 1) * per + span + 1;
        eng_mode = mode;
        eng_lat  = lat;
        for (int c = 0; c < last; c++) begin
            input_valid_n = 1'b1;
            matrix        = m0;
            if (c == 0) input_valid_n = 1'b0;
            if (nmat == 2 && c >= 1) begin
                matrix = m1;
                if (c <= per) input_valid_n = 1'b0;
            end
            if (pulses && (c == 3 || c == 10)) begin
                matrix        = m1;
                input_valid_n = 1'b0;
            end
            tick();
            t = c + 1;
            busy_e = 1'b0; rel = 0; j = 0;
            for (int k = 0; k < nmat; k++) begin
                if (t > k * per && t <= k * per + span) begin
                    busy_e = 1'b1;
                    rel    = t - k * per;
                    j      = k;
                end
            end
            eng_e = busy_e && ((rel - 1) % (lat + 1) == 0) && (rel - 1 < R * (lat + 1));
            ov_e  = busy_e && (rel == span);
            chk("eng_valid_n", MW'(eng_valid_n), MW'(!eng_e));
            chk("output_valid_n", MW'(output_valid_n), MW'(!ov_e));
            chk("busy", MW'(busy), MW'(busy_e));
            chk("input_ready_n", MW'(input_ready_n), MW'(busy_e));
            chk("timeout_err", MW'(timeout_err), MW'(0));
            if (busy_e && !ov_e) begin
                row = (rel - 1) / (lat + 1);
                chk("eng_inputs", MW'(eng_inputs), MW'(row_of((j == 0) ? m0 : m1, row)));
            end
            if (ov_e) chk("softmax_matrix", softmax_matrix, expect_mat((j == 0) ? m0 : m1));
        end
        input_valid_n = 1'b1;
    endtask

    initial begin
        logic [MW-1:0] ma, mb;
        rst_n         = 1'b0;
        input_valid_n = 1'b1;
        matrix        = '0;
        tick();
        tick();
        chk("rst input_ready_n", MW'(input_ready_n), MW'(0));
        chk("rst output_valid_n", MW'(output_valid_n), MW'(1));
        chk("rst eng_valid_n", MW'(eng_valid_n), MW'(1));
        chk("rst busy", MW'(busy), MW'(0));
        chk("rst timeout_err", MW'(timeout_err), MW'(0));
        chk("rst softmax_matrix", softmax_matrix, MW'(0));
        chk("rst eng_inputs", MW'(eng_inputs), MW'(0));
        rst_n = 1'b1;
        tick();

        // Rows hold their own index in every element.
        ma = '0;
        for (int k = 0; k < R; k++)
            for (int e = 0; e < N; e++) ma[(k*N + e)*DW +: DW] = 8'(k);
        run_seq(3, 0, ma, '0, 1, 1'b0);

        // Offers during a run are dropped.
        ma = rand_mat();
        mb = rand_mat();
        run_seq(3, 0, ma, mb, 1, 1'b1);

        // Engine valid held low: ISSUE-cycle level ignored, two cycles per row.
        ma = rand_mat();
        run_seq(1, 1, ma, '0, 1, 1'b0);
        eng_mode = 0;
        tick();

        // Engine never answers: timeout after 8 WAIT cycles.
        eng_mode      = 2;
        matrix        = rand_mat();
        input_valid_n = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            input_valid_n = 1'b1;
            chk("tmo output_valid_n", MW'(output_valid_n), MW'(1));
            chk("tmo busy", MW'(busy), MW'((t <= 9) ? 1 : 0));
            chk("tmo timeout_err", MW'(timeout_err), MW'((t <= 9) ? 0 : 1));
        end
        tick();
        chk("tmo sticky", MW'(timeout_err), MW'(1));
        chk("tmo idle ready", MW'(input_ready_n), MW'(0));
        ma = rand_mat();
        run_seq(2, 0, ma, '0, 1, 1'b0);

        // Reset during WAIT of row 2; the late engine answer must be ignored.
        eng_mode      = 0;
        eng_lat       = 3;
        ma            = rand_mat();
        matrix        = ma;
        input_valid_n = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            input_valid_n = 1'b1;
        end
        chk("pre-rst eng_inputs row2", MW'(eng_inputs), MW'(row_of(ma, 2)));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid-rst input_ready_n", MW'(input_ready_n), MW'(0));
        chk("mid-rst output_valid_n", MW'(output_valid_n), MW'(1));
        chk("mid-rst eng_valid_n", MW'(eng_valid_n), MW'(1));
        chk("mid-rst busy", MW'(busy), MW'(0));
        chk("mid-rst softmax_matrix", softmax_matrix, MW'(0));
        chk("mid-rst eng_inputs", MW'(eng_inputs), MW'(0));
        tick();
        tick();
        chk("late resp busy", MW'(busy), MW'(0));
        chk("late resp output_valid_n", MW'(output_valid_n), MW'(1));
        chk("late resp softmax_matrix", softmax_matrix, MW'(0));
        ma = rand_mat();
        run_seq(3, 0, ma, '0, 1, 1'b0);

        // Back-to-back with valid held low.
        ma = rand_mat();
        mb = rand_mat();
        run_seq(3, 0, ma, mb, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/softmax_row_scheduler.md
# softmax_row_scheduler

Time-multiplexing controller that computes a row-wise softmax over an `INPUT_SHAPE_1 × INPUT_SHAPE_2` matrix using a single shared `softmax` engine instead of one engine per row.

- It latches a whole matrix and issues rows one at a time to the engine.
- It collects each result row, then presents the assembled output matrix with a one-cycle active-low valid.
- It sits between the attention-score producer and the downstream matmul, in area-constrained builds.

## Interface
Parameters:
- `DATA_WIDTH`, 8: element width (signed).
- `INPUT_SHAPE_1`, 128: number of rows (R); must be ≥1.
- `INPUT_SHAPE_2`, 128: elements per row.
- `TIMEOUT_CYCLES`, 1024: maximum number of cycles spent in WAIT per row; 0 disables the timeout.

Ports:
- `clk_p` input, 1: single clock. All logic is on the rising edge.
- `rst_n` input, 1: reset, synchronous, active-low.
- `matrix` input, DATA_WIDTH·R·INPUT_SHAPE_2: input matrix. Row i occupies bits [(i+1)·DATA_WIDTH·INPUT_SHAPE_2−1 : i·DATA_WIDTH·INPUT_SHAPE_2].
- `input_valid_n` input, 1: low = `matrix` offered this cycle.
- `input_ready_n` output, 1: low = scheduler is IDLE and accepts a matrix.
- `softmax_matrix` output, DATA_WIDTH·R·INPUT_SHAPE_2: result matrix, using the same row packing as `matrix`.
- `output_valid_n` output, 1: low for exactly one cycle when `softmax_matrix` is complete.
- `busy` output, 1: high whenever the state is not IDLE.
- `timeout_err` output, 1: sticky high after an engine timeout.
- `eng_inputs` output, DATA_WIDTH·INPUT_SHAPE_2: current row sent to the engine.
- `eng_valid_n` output, 1: low for one cycle to start the engine.
- `eng_outputs` input, DATA_WIDTH·INPUT_SHAPE_2: engine result row.
- `eng_valid_out_n` input, 1: low = `eng_outputs` valid.

## Operation
FSM states: IDLE, ISSUE, WAIT, DONE.

- **IDLE**
  - `input_ready_n`=0.
  - If `input_valid_n`=0: latch `matrix` into the input buffer, row index=0, clear `timeout_err`, go to ISSUE.
- **ISSUE**
  - `eng_valid_n`=0 and `eng_inputs`=buffer row[index].
  - Clear the timeout counter.
  - Go to WAIT next cycle unconditionally.
- **WAIT**
  - `eng_inputs` holds the row.
  - If `eng_valid_out_n`=0 on the first such cycle:
    - write `eng_outputs` into output register row[index];
    - if index=R−1, go to DONE;
    - otherwise increment index and go to ISSUE.
  - Otherwise increment the timeout counter. If `TIMEOUT_CYCLES`≠0 and the counter reaches `TIMEOUT_CYCLES`: set `timeout_err`=1 and go to IDLE without asserting `output_valid_n`.
- **DONE**
  - `output_valid_n`=0 for this one cycle, then go to IDLE.

Boundary rules:
- `eng_valid_out_n` is sampled only in WAIT. A low level seen during ISSUE/IDLE/DONE is ignored.
- `input_valid_n` is ignored outside IDLE; the matrix is dropped, with no queueing. The producer must honour `input_ready_n`.
- A new matrix may be accepted in the IDLE cycle that directly follows DONE.
- `softmax_matrix` is written row-wise as results arrive. It is meaningful only in the DONE cycle, and it holds its value until overwritten by the next run.
- With R=1, the sequence is ISSUE → WAIT → DONE.
- Reset mid-operation: back to IDLE; the in-flight engine result is discarded. The engine must be reset by the same `rst_n`.
- Row index width is max(1,$clog2(R)). The timeout counter width is max(1,$clog2(TIMEOUT_CYCLES+1)).

## Timing
- Reset values:
  - state=IDLE;
  - `input_ready_n`=0, `output_valid_n`=1, `eng_valid_n`=1;
  - `busy`=0, `timeout_err`=0;
  - `softmax_matrix`=0, `eng_inputs`=0, index=0.
- All outputs are decoded from registered state or are registers. There are no input-to-output combinational paths.
- Let engine latency L ≥ 1 be the number of cycles from the ISSUE cycle to the first low cycle of `eng_valid_out_n`.
- With the matrix accepted at cycle 0:
  - row k is issued at cycle 1+k·(L+1);
  - row k is captured at cycle (k+1)·(L+1);
  - `output_valid_n` is low at cycle R·(L+1)+1.
- Throughput: one matrix per R·(L+1)+2 cycles.

## Structure
- Shared package `softmax_sched_pkg`:
  - state enum (IDLE, ISSUE, WAIT, DONE);
  - row-slice width function DATA_WIDTH·INPUT_SHAPE_2.
- No sub-module inside the scheduler. The row mux and the output row-write are generate loops.
- The engine is instantiated beside the scheduler in a thin top, `softmax_matrix_serial`: `softmax` with INPUT_NUM=OUTPUT_NUM=INPUT_SHAPE_2.

## Test plan
Test parameters: R=4, INPUT_SHAPE_2=4, DATA_WIDTH=8, and an engine model with L=3 that outputs row+1 per element.
1. Reset, then one matrix with rows 0x00…0x03 → `eng_valid_n` pulses at cycles 1, 5, 9, 13; `output_valid_n`=0 at cycle 17 only; each row of `softmax_matrix` is the input row +1.
2. `input_valid_n` pulsed low at cycles 3 and 10 during a run → ignored; `input_ready_n`=1 and `busy`=1 throughout; the result is from the first matrix only.
3. Engine holds `eng_valid_out_n` low continuously → the ISSUE-cycle level is ignored; each row is captured on the first WAIT cycle, so per-row time is 2 cycles; `output_valid_n` is low at cycle 9.
4. `TIMEOUT_CYCLES`=8 and the engine never responds → `timeout_err`=1 after 8 WAIT cycles, state returns to IDLE, `output_valid_n` is never low; the next accepted matrix clears `timeout_err`.
5. `rst_n` low during WAIT of row 2 → the next cycle shows the reset values above; a late engine response is ignored; a fresh matrix completes normally.
6. Back-to-back matrices with `input_valid_n` held low → the second is accepted in the IDLE cycle after DONE (cycle 18), and its `output_valid_n` is at cycle 35.
